// File: rtl/common_serdecr_n_pkg.sv
// +----------------------------------------------------------------------------+
// | common_serdecr_n_pkg : shared FSM encoding and sizing helpers              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package common_serdecr_n_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic int nibbles(input int width);
    return width / 4;
  endfunction

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/common_rtlrom_decr4.sv
// +----------------------------------------------------------------------------+
// | common_rtlrom_decr4 : 4-bit decrement ROM slice, q = d-1, b = (d == 0)     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module common_rtlrom_decr4 (
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       b
);

  always_comb begin
    q = 4'h0;
    b = 1'b0;
    case (d)
      4'h0: begin q = 4'hF; b = 1'b1; end
      4'h1: q = 4'h0;
      4'h2: q = 4'h1;
      4'h3: q = 4'h2;
      4'h4: q = 4'h3;
      4'h5: q = 4'h4;
      4'h6: q = 4'h5;
      4'h7: q = 4'h6;
      4'h8: q = 4'h7;
      4'h9: q = 4'h8;
      4'hA: q = 4'h9;
      4'hB: q = 4'hA;
      4'hC: q = 4'hB;
      4'hD: q = 4'hC;
      4'hE: q = 4'hD;
      4'hF: q = 4'hE;
      default: begin q = 4'h0; b = 1'b0; end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/common_serdecr_n.sv
// +----------------------------------------------------------------------------+
// | common_serdecr_n : nibble-serial unsigned decrementer with valid/ready     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module common_serdecr_n
  import common_serdecr_n_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] o_q,
  output logic             o_b
);

  localparam int N  = nibbles(WIDTH);
  localparam int IW = idx_bits(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_nx;
  logic [IW-1:0]    idx;
  logic             borrow;
  logic             borrow_nx;
  logic             last_step;
  logic [3:0]       nib;
  logic [3:0]       nib_dec;
  logic             nib_b;

  always_comb begin
    nib = 4'h0;
    for (int n = 0; n < N; n++) begin
      if (idx == IW'(n)) nib = work[n*4 +: 4];
    end
  end

  common_rtlrom_decr4 u_rom (
    .d (nib),
    .q (nib_dec),
    .b (nib_b)
  );

  // Once the borrow has cleared the remaining nibbles pass through untouched.
  always_comb begin
    borrow_nx = borrow & nib_b;
    work_nx   = work;
    if (borrow) begin
      for (int n = 0; n < N; n++) begin
        if (idx == IW'(n)) work_nx[n*4 +: 4] = nib_dec;
      end
    end
    last_step = (idx == LAST) || (EARLY_EXIT && !borrow_nx);
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (i_valid)   state_nx = ST_BUSY;
      ST_BUSY: if (last_step) state_nx = ST_DONE;
      ST_DONE: if (o_ready)   state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      work   <= '0;
      idx    <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            work   <= i_d;
            borrow <= 1'b1;
            idx    <= '0;
          end
        end
        ST_BUSY: begin
          work   <= work_nx;
          borrow <= borrow_nx;
          if (!last_step) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    i_ready = (state == ST_IDLE);
    o_valid = (state == ST_DONE);
    o_q     = o_valid ? work : '0;
    o_b     = o_valid & borrow;
  end

endmodule

`default_nettype wire

// File: tb/tb_common_serdecr_n.sv
// +----------------------------------------------------------------------------+
// | tb_common_serdecr_n : randomized self-checking bench for common_serdecr_n  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_common_serdecr_n;

  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic             i_valid, i_ready, o_valid, o_ready, o_b;
  logic [WIDTH-1:0] i_d, o_q;
  logic             e0_i_valid, e0_i_ready, e0_o_valid, e0_o_ready, e0_o_b;
  logic [WIDTH-1:0] e0_i_d, e0_o_q;
  logic [3:0]       rom_d, rom_q;
  logic             rom_b;

  int n_cmp  = 0;
  int n_fail = 0;

  common_serdecr_n #(.WIDTH(WIDTH), .EARLY_EXIT(1'b1)) dut (
    .clk(clk), .resetn(resetn),
    .i_valid(i_valid), .i_ready(i_ready), .i_d(i_d),
    .o_valid(o_valid), .o_ready(o_ready), .o_q(o_q), .o_b(o_b)
  );

  common_serdecr_n #(.WIDTH(WIDTH), .EARLY_EXIT(1'b0)) dut_full (
    .clk(clk), .resetn(resetn),
    .i_valid(e0_i_valid), .i_ready(e0_i_ready), .i_d(e0_i_d),
    .o_valid(e0_o_valid), .o_ready(e0_o_ready), .o_q(e0_o_q), .o_b(e0_o_b)
  );

  common_rtlrom_decr4 rom (.d(rom_d), .q(rom_q), .b(rom_b));

  // Reference: plain modular arithmetic and first-nonzero-nibble latency.
  function automatic logic [WIDTH-1:0] ref_q(input logic [WIDTH-1:0] d);
    return d - 1'b1;
  endfunction

  function automatic int ref_lat(input logic [WIDTH-1:0] d, input bit early);
    if (!early) return N;
    for (int i = 0; i < N; i++) if (d[i*4 +: 4] != 4'h0) return i + 1;
    return N;
  endfunction

  task automatic transact(input logic [WIDTH-1:0] d, input int bp,
                          output logic [WIDTH-1:0] q, output logic b,
                          output int lat, output logic rdy_after);
    int guard;
    guard = 0;
    lat = -1; q = 'x; b = 1'bx; rdy_after = 1'b0;
    while (!i_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    i_valid = 1'b1; i_d = d; o_ready = (bp == 0);
    @(posedge clk); #1;
    i_valid = 1'b0; i_d = WIDTH'($urandom);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (o_valid) begin lat = c; break; end
    end
    if (lat < 0) return;
    q = o_q; b = o_b;
    for (int c = 0; c < bp; c++) begin @(posedge clk); #1; end
    o_ready = 1'b1;
    @(posedge clk); #1;
    rdy_after = i_ready && !o_valid;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_q !== '0) begin n_fail++; $display("FAIL reset_o_q: got %h want 0000", o_q); end
    n_cmp++; if (o_b !== 1'b0) begin n_fail++; $display("FAIL reset_o_b: got %b want 0", o_b); end
    n_cmp++; if (i_ready !== 1'b1) begin n_fail++; $display("FAIL reset_i_ready: got %b want 1", i_ready); end
    n_cmp++; if (e0_i_ready !== 1'b1) begin n_fail++; $display("FAIL reset_full_i_ready: got %b want 1", e0_i_ready); end
    resetn = 1'b1;
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] vec [4];
    logic [WIDTH-1:0] q;
    logic b, rdy;
    int lat;
    vec = '{16'h0001, 16'h1000, 16'h0000, 16'hA5F0};
    for (int i = 0; i < 4; i++) begin
      transact(vec[i], 0, q, b, lat, rdy);
      n_cmp++; if (q !== ref_q(vec[i])) begin n_fail++; $display("FAIL dir_q[%h]: got %h want %h", vec[i], q, ref_q(vec[i])); end
      n_cmp++; if (b !== (vec[i] == '0)) begin n_fail++; $display("FAIL dir_b[%h]: got %b want %b", vec[i], b, vec[i] == '0); end
      n_cmp++; if (lat != ref_lat(vec[i], 1'b1)) begin n_fail++; $display("FAIL dir_lat[%h]: got %0d want %0d", vec[i], lat, ref_lat(vec[i], 1'b1)); end
      n_cmp++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL dir_ready_after[%h]: got %b want 1", vec[i], rdy); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    lat = -1;
    o_ready = 1'b0; i_valid = 1'b1; i_d = 16'h0010;
    @(posedge clk); #1;
    i_valid = 1'b0; i_d = 16'hFFFF;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (o_valid) begin lat = c; break; end
    end
    n_cmp++; if (lat != ref_lat(16'h0010, 1'b1)) begin n_fail++; $display("FAIL bp_lat: got %0d want %0d", lat, ref_lat(16'h0010, 1'b1)); end
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if (o_valid !== 1'b1 || o_q !== 16'h000F || o_b !== 1'b0 || i_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%b q=%h b=%b rdy=%b want v=1 q=000f b=0 rdy=0", c, o_valid, o_q, o_b, i_ready);
      end
      @(posedge clk); #1;
    end
    o_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (o_valid !== 1'b0 || i_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got v=%b rdy=%b want v=0 rdy=1", o_valid, i_ready); end
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] q;
    logic b, rdy;
    int lat, seen;
    seen = 0;
    i_valid = 1'b1; i_d = 16'h8000; o_ready = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (o_valid !== 1'b0 || o_q !== '0 || i_ready !== 1'b1) begin
      n_fail++; $display("FAIL midreset_state: got v=%b q=%h rdy=%b want v=0 q=0000 rdy=1", o_valid, o_q, i_ready);
    end
    resetn = 1'b1;
    for (int c = 0; c < 6; c++) begin @(posedge clk); #1; if (o_valid) seen++; end
    n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL midreset_no_output: got %0d valid cycles want 0", seen); end
    transact(16'h0002, 0, q, b, lat, rdy);
    n_cmp++; if (q !== 16'h0001 || b !== 1'b0) begin n_fail++; $display("FAIL midreset_next: got q=%h b=%b want q=0001 b=0", q, b); end
    n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL midreset_next_lat: got %0d want 1", lat); end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] d, q;
    logic b, rdy;
    int lat;
    for (int it = 0; it < 40; it++) begin
      d = WIDTH'($urandom);
      for (int i = 0; i < N; i++) if ($urandom_range(0, 1) == 1) d[i*4 +: 4] = 4'h0;
      transact(d, int'($urandom_range(0, 3)), q, b, lat, rdy);
      n_cmp++; if (q !== ref_q(d) || b !== (d == '0)) begin
        n_fail++; $display("FAIL rnd_result[%h]: got q=%h b=%b want q=%h b=%b", d, q, b, ref_q(d), d == '0);
      end
      n_cmp++; if (lat != ref_lat(d, 1'b1) || rdy !== 1'b1) begin
        n_fail++; $display("FAIL rnd_timing[%h]: got lat=%0d rdy=%b want lat=%0d rdy=1", d, lat, rdy, ref_lat(d, 1'b1));
      end
    end
  endtask

  task automatic test_no_early_exit();
    logic [WIDTH-1:0] vec [6];
    logic [WIDTH-1:0] q;
    logic b;
    int lat, guard;
    vec = '{16'h0005, 16'h0000, 16'h1000, 16'hFFFF, WIDTH'($urandom), WIDTH'($urandom)};
    e0_o_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      guard = 0;
      while (!e0_i_ready && guard < 50) begin @(posedge clk); #1; guard++; end
      e0_i_valid = 1'b1; e0_i_d = vec[i];
      @(posedge clk); #1;
      e0_i_valid = 1'b0; e0_i_d = WIDTH'($urandom);
      lat = -1; q = 'x; b = 1'bx;
      for (int c = 1; c <= 20; c++) begin
        @(posedge clk); #1;
        if (e0_o_valid) begin lat = c; q = e0_o_q; b = e0_o_b; break; end
      end
      n_cmp++; if (q !== ref_q(vec[i]) || b !== (vec[i] == '0)) begin
        n_fail++; $display("FAIL full_result[%h]: got q=%h b=%b want q=%h b=%b", vec[i], q, b, ref_q(vec[i]), vec[i] == '0);
      end
      n_cmp++; if (lat != ref_lat(vec[i], 1'b0)) begin n_fail++; $display("FAIL full_lat[%h]: got %0d want %0d", vec[i], lat, ref_lat(vec[i], 1'b0)); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rom_sweep();
    logic [3:0] exp_q;
    for (int v = 0; v < 16; v++) begin
      rom_d = 4'(v);
      exp_q = 4'((v + 15) % 16);
      #1;
      n_cmp++; if (rom_q !== exp_q || rom_b !== (v == 0)) begin
        n_fail++; $display("FAIL rom[%0d]: got q=%h b=%b want q=%h b=%b", v, rom_q, rom_b, exp_q, v == 0);
      end
    end
  endtask

  initial begin
    i_valid = 1'b0; i_d = '0; o_ready = 1'b0;
    e0_i_valid = 1'b0; e0_i_d = '0; e0_o_ready = 1'b0;
    rom_d = 4'h0;
    test_reset();
    test_rom_sweep();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_no_early_exit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
